// File: rtl/fetch_sequencer.sv
// RV32I instruction fetch sequencer: one outstanding imem request, a 2-entry
// instruction buffer toward decode, and redirect handling that drops stale responses.
module fetch_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   output logic        o_ImemReq,
   output logic [31:0] o_ImemAddr,
   input  logic        i_ImemGnt,
   input  logic        i_ImemRvalid,
   input  logic [31:0] i_ImemRdata,
   output logic        o_InstValid,
   output logic [31:0] o_Instruction,
   output logic [31:0] o_InstPC,
   input  logic        i_DecodeReady,
   input  logic        i_Redirect,
   input  logic [31:0] i_RedirectPC
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DROP = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_pc;
   logic [31:0] w_pc_nxt;
   logic [31:0] r_fetch_pc;
   logic [1:0]  r_count;
   logic [1:0]  w_count_nxt;
   logic        r_req;
   logic        r_valid;
   logic [31:0] r_inst0;
   logic [31:0] r_inst1;
   logic [31:0] r_ipc0;
   logic [31:0] r_ipc1;
   logic        w_pop;
   logic        w_push;
   logic [31:0] w_redirect_pc;

   // Next-state, next-PC and buffer occupancy; a redirect overrides every other event.
   always_comb begin
      w_state_nxt   = r_state;
      w_pc_nxt      = r_pc;
      w_count_nxt   = r_count;
      w_redirect_pc = i_RedirectPC & 32'hFFFF_FFFC;
      w_pop         = (r_count != 2'd0) && i_DecodeReady && !i_Redirect;
      w_push        = (r_state == S_WAIT) && i_ImemRvalid && !i_Redirect;

      if (i_Redirect) begin
         w_count_nxt = 2'd0;
      end else begin
         case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 2'd1;
            2'b01:   w_count_nxt = r_count - 2'd1;
            default: w_count_nxt = r_count;
         endcase
      end

      if (i_Redirect) begin
         w_pc_nxt = w_redirect_pc;
      end else if ((r_state == S_REQ) && i_ImemGnt) begin
         w_pc_nxt = r_pc + 32'd4;
      end else begin
         w_pc_nxt = r_pc;
      end

      case (r_state)
         S_IDLE: begin
            if (i_Redirect || (r_count < 2'd2)) w_state_nxt = S_REQ;
            else                                w_state_nxt = S_IDLE;
         end
         S_REQ: begin
            if (i_ImemGnt) w_state_nxt = i_Redirect ? S_DROP : S_WAIT;
            else           w_state_nxt = S_REQ;
         end
         S_WAIT: begin
            if (i_ImemRvalid) begin
               if (i_Redirect || (w_count_nxt < 2'd2)) w_state_nxt = S_REQ;
               else                                     w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = i_Redirect ? S_DROP : S_WAIT;
            end
         end
         S_DROP: begin
            if (i_ImemRvalid) w_state_nxt = S_REQ;
            else              w_state_nxt = S_DROP;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Control state, PC, occupancy and the registered request/valid outputs.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state    <= S_IDLE;
         r_pc       <= RESET_PC;
         r_fetch_pc <= RESET_PC;
         r_count    <= 2'd0;
         r_req      <= 1'b0;
         r_valid    <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_pc       <= w_pc_nxt;
         r_fetch_pc <= ((r_state == S_REQ) && i_ImemGnt) ? r_pc : r_fetch_pc;
         r_count    <= w_count_nxt;
         r_req      <= (w_state_nxt == S_REQ);
         r_valid    <= (w_count_nxt != 2'd0);
      end
   end

   // Shift-style 2-entry FIFO: entry 0 is always the head presented to decode.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_inst0 <= 32'd0;
         r_inst1 <= 32'd0;
         r_ipc0  <= 32'd0;
         r_ipc1  <= 32'd0;
      end else begin
         case ({w_push, w_pop})
            2'b10: begin
               if (r_count == 2'd0) begin
                  r_inst0 <= i_ImemRdata;
                  r_ipc0  <= r_fetch_pc;
               end else begin
                  r_inst1 <= i_ImemRdata;
                  r_ipc1  <= r_fetch_pc;
               end
            end
            2'b01: begin
               r_inst0 <= r_inst1;
               r_ipc0  <= r_ipc1;
            end
            2'b11: begin
               if (r_count == 2'd1) begin
                  r_inst0 <= i_ImemRdata;
                  r_ipc0  <= r_fetch_pc;
               end else begin
                  r_inst0 <= r_inst1;
                  r_ipc0  <= r_ipc1;
                  r_inst1 <= i_ImemRdata;
                  r_ipc1  <= r_fetch_pc;
               end
            end
            default: begin
               r_inst0 <= r_inst0;
               r_ipc0  <= r_ipc0;
            end
         endcase
      end
   end

   assign o_ImemReq     = r_req;
   assign o_ImemAddr    = r_pc;
   assign o_InstValid   = r_valid;
   assign o_Instruction = r_inst0;
   assign o_InstPC      = r_ipc0;

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction fetch sequencer for the RV32I core. It holds the program counter and issues word fetches to instruction memory through a request/grant/response handshake. Returned words go into a 2-entry buffer, which presents instructions and their PCs to the decode stage (opcode decode and immediate generation) under a valid/ready handshake. Branch/jump redirects from execute flush the buffer and discard any stale in-flight response.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset (bits [1:0] must be 0)

Ports:
- i_clk  in  1  single clock; all state updates on rising edge
- i_rst_n  in  1  reset, synchronous, active-low
- o_ImemReq  out  1  fetch request valid
- o_ImemAddr  out  32  fetch word address, equal to PC
- i_ImemGnt  in  1  memory accepted the request this cycle
- i_ImemRvalid  in  1  read data valid for the single outstanding request
- i_ImemRdata  in  32  instruction word
- o_InstValid  out  1  buffer head holds a valid instruction
- o_Instruction  out  32  buffer head instruction
- o_InstPC  out  32  PC of the buffer head instruction
- i_DecodeReady  in  1  decode consumes the head when o_InstValid is also high
- i_Redirect  in  1  control-flow redirect, single-cycle pulse
- i_RedirectPC  in  32  redirect target; bits [1:0] are forced to 0 internally

## Operation
- Only one fetch is outstanding at a time (granted, response not yet returned).
- State machine: IDLE, REQ, WAIT, DROP.
  - IDLE: o_ImemReq=0. Go to REQ when buffer count < 2.
  - REQ: o_ImemReq=1, o_ImemAddr=PC, both held stable until i_ImemGnt. On grant: PC <= PC+4 (mod 2^32), go to WAIT.
  - WAIT: on i_ImemRvalid, push {i_ImemRdata, fetch PC} into the buffer. Then go to REQ if the post-pop count is < 2, else IDLE.
  - DROP: the outstanding response is stale. On i_ImemRvalid, discard the data and go to REQ.
- The fetch PC of each outstanding request is kept in a register and is pushed alongside its data.
- Buffer: 2-entry FIFO.
  - Pop when o_InstValid && i_DecodeReady.
  - o_InstValid = (count != 0).
  - o_Instruction and o_InstPC come from registers (head entry).
  - Push and pop in the same cycle are allowed. Push when full cannot occur because requests are gated on count < 2.
- Redirect (i_Redirect=1) has priority over every other event in that cycle:
  - buffer is flushed (count <= 0; o_InstValid=0 next cycle); any pop that cycle is ignored
  - PC <= {i_RedirectPC[31:2], 2'b00}
  - from REQ without grant: stay in REQ with the new PC
  - from REQ with i_ImemGnt the same cycle: go to DROP (the granted request is stale)
  - from WAIT without i_ImemRvalid: go to DROP
  - from WAIT with i_ImemRvalid the same cycle: discard the data, go to REQ
  - from DROP without i_ImemRvalid: stay in DROP
  - from DROP with i_ImemRvalid: go to REQ
  - from IDLE: go to REQ
- i_ImemRvalid in IDLE or REQ is a protocol error and is ignored.

## Timing
- Reset (i_rst_n=0 at a clock edge):
  - state=IDLE, PC=RESET_PC, count=0
  - o_ImemReq=0, o_ImemAddr=RESET_PC, o_InstValid=0, o_Instruction=0, o_InstPC=0
- First request: IDLE evaluates in the first cycle after reset release, so o_ImemReq=1 in the second cycle.
- Grant in cycle N: the earliest response is N+1. The memory response latency is unbounded.
- Response in cycle N: o_InstValid=1 at N+1. The next o_ImemReq is asserted at N+1 if space remains.
- With a zero-wait memory (grant on first request cycle, response the next cycle), steady-state throughput is one instruction every 2 cycles.
- Redirect in cycle N: o_ImemAddr = target at N+1 in REQ, unless in DROP. o_InstValid=0 at N+1.
- Reset asserted mid-fetch: all state returns to reset values on that edge. A response arriving after reset release is ignored (state is IDLE/REQ).

## Test plan
- Reset, then a zero-wait memory returning 32'h00500093 at address 0 and 32'h00A00113 at address 4, with i_DecodeReady=1: o_ImemAddr sequence 0,4,8; o_InstValid pulses with o_InstPC=0, then 4.
- i_DecodeReady=0 for 10 cycles: exactly 2 entries buffered, o_ImemReq=0 (IDLE); releasing ready drains PC 0,4 in order and fetching resumes at 8.
- Grant withheld for 5 cycles in REQ: o_ImemReq and o_ImemAddr=0 stay stable all 5 cycles; PC advances only on the grant cycle.
- Redirect to 32'h0000_0103 while in WAIT, response arriving 3 cycles later: response discarded, next o_ImemAddr=32'h0000_0100, buffer empty until the new data returns.
- Redirect in the same cycle as a grant, and separately in the same cycle as a response: both go through DROP or discard as specified; no stale instruction ever appears on o_InstValid.
- i_rst_n low for one cycle while in WAIT, with a response arriving the cycle after release: ignored; the fetch restarts at RESET_PC with reset output values as listed.
